// File: rtl/module_control_unit_pkg.sv
// Shared definitions for the mini-CPU control unit: state and opcode encodings,
// the instruction word layout and small helpers used by the sequencer.
package module_control_unit_pkg;

    localparam int unsigned INSTR_W = 18;

    typedef enum logic [2:0] {
        ST_OFF    = 3'b000,
        ST_FETCH  = 3'b001,
        ST_DECODE = 3'b010,
        ST_READ   = 3'b011,
        ST_CALC   = 3'b100,
        ST_WAIT   = 3'b101,
        ST_STORE  = 3'b110,
        ST_SHOW   = 3'b111
    } cpu_state_t;

    typedef enum logic [2:0] {
        OP_LOAD    = 3'b000,
        OP_ADD     = 3'b001,
        OP_ADDI    = 3'b010,
        OP_SUB     = 3'b011,
        OP_SUBI    = 3'b100,
        OP_MUL     = 3'b101,
        OP_CLEAR   = 3'b110,
        OP_DISPLAY = 3'b111
    } opcode_t;

    // tail holds src2 in [6:3] or sign/immediate in [6]/[5:0], depending on opcode
    typedef struct packed {
        logic [2:0] opcode;
        logic [3:0] dest;
        logic [3:0] src1;
        logic [6:0] tail;
    } instr_t;

    function automatic logic writes_ram(input opcode_t op);
        return (op != OP_CLEAR) && (op != OP_DISPLAY);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/module_control_unit_if.sv
// Bus between the control unit and its environment (switches, ALU strobes, RAM/LCD).
// slave is the control-unit side, master the side that drives its inputs.
interface module_control_unit_if;
    import module_control_unit_pkg::*;

    logic               power;
    logic               send;
    logic [INSTR_W-1:0] instr;
    logic               decoded;
    logic               calculated;
    logic [2:0]         stateCPU;
    logic [2:0]         opcode;
    logic               sinalImm;
    logic [5:0]         Imm;
    logic [3:0]         addrDest;
    logic [3:0]         addrSrc1;
    logic [3:0]         addrSrc2;
    logic               ramWrite;
    logic               ramClear;
    logic               lcdUpdate;
    logic               error;

    modport master (
        output power, send, instr, decoded, calculated,
        input  stateCPU, opcode, sinalImm, Imm, addrDest, addrSrc1, addrSrc2,
               ramWrite, ramClear, lcdUpdate, error
    );

    modport slave (
        input  power, send, instr, decoded, calculated,
        output stateCPU, opcode, sinalImm, Imm, addrDest, addrSrc1, addrSrc2,
               ramWrite, ramClear, lcdUpdate, error
    );

endinterface

// File: rtl/module_control_unit_edge_detect.sv
// Single-flop rising-edge detector for the send button level.
module module_control_unit_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= in_i;
        end
    end

    assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/module_control_unit.sv
// Mini-CPU sequencer: latches an instruction on a send press, steps OFF..SHOW on the
// ALU strobes and issues one-cycle RAM write/clear and LCD refresh pulses.
module module_control_unit
    import module_control_unit_pkg::*;
#(
    parameter int unsigned READ_CYCLES = 1,
    parameter int unsigned SHOW_CYCLES = 4,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    module_control_unit_if.slave bus
);

    localparam int unsigned CNT_MAX = max3(READ_CYCLES, SHOW_CYCLES, TIMEOUT);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

    cpu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    instr_t           instr_q, instr_d;
    logic             error_q, error_d;
    logic             ramWrite_q, ramWrite_d;
    logic             ramClear_q, ramClear_d;
    logic             lcdUpdate_q, lcdUpdate_d;
    logic             send_rise;
    opcode_t          op;

    module_control_unit_edge_detect u_send_edge (
        .clk    (clk),
        .reset  (reset),
        .in_i   (bus.send),
        .rise_o (send_rise)
    );

    assign op = opcode_t'(instr_q.opcode);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_OFF;
            cnt_q       <= '0;
            instr_q     <= '0;
            error_q     <= 1'b0;
            ramWrite_q  <= 1'b0;
            ramClear_q  <= 1'b0;
            lcdUpdate_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            instr_q     <= instr_d;
            error_q     <= error_d;
            ramWrite_q  <= ramWrite_d;
            ramClear_q  <= ramClear_d;
            lcdUpdate_q <= lcdUpdate_d;
        end
    end

    // Pulses are computed on the transition into their owning state so that they
    // are visible exactly while stateCPU shows that state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        instr_d     = instr_q;
        error_d     = error_q;
        ramWrite_d  = 1'b0;
        ramClear_d  = 1'b0;
        lcdUpdate_d = 1'b0;

        if (!bus.power) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d    = ST_FETCH;
                    ramClear_d = 1'b1;
                end
                ST_FETCH: begin
                    if (send_rise) begin
                        instr_d = bus.instr;
                        error_d = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (bus.decoded) begin
                        cnt_d   = '0;
                        state_d = ST_READ;
                    end else if (cnt_q == TO_LAST) begin
                        error_d = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_READ: begin
                    if (cnt_q == READ_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CALC: begin
                    if (bus.calculated) begin
                        state_d = ST_WAIT;
                    end else if (cnt_q == TO_LAST) begin
                        error_d = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    state_d    = ST_STORE;
                    ramWrite_d = writes_ram(op);
                    ramClear_d = (op == OP_CLEAR);
                end
                ST_STORE: begin
                    cnt_d       = '0;
                    lcdUpdate_d = 1'b1;
                    state_d     = ST_SHOW;
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = ST_FETCH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    assign bus.stateCPU  = state_q;
    assign bus.opcode    = instr_q.opcode;
    assign bus.addrDest  = instr_q.dest;
    assign bus.addrSrc1  = instr_q.src1;
    assign bus.addrSrc2  = instr_q.tail[6:3];
    assign bus.sinalImm  = instr_q.tail[6];
    assign bus.Imm       = instr_q.tail[5:0];
    assign bus.ramWrite  = ramWrite_q;
    assign bus.ramClear  = ramClear_q;
    assign bus.lcdUpdate = lcdUpdate_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_module_control_unit.sv
// Bench for module_control_unit: builds an expected per-cycle trace from instruction-level
// rules (dwell lengths, strobe delays, power/reset drops) and replays it against the DUT.
module tb_module_control_unit;

    localparam int unsigned READ_CYCLES = 1;
    localparam int unsigned SHOW_CYCLES = 4;
    localparam int unsigned TIMEOUT     = 15;

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_CALC   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_STORE  = 3'd6;
    localparam logic [2:0] S_SHOW   = 3'd7;

    typedef struct {
        bit          rst;
        bit          pwr;
        bit          snd;
        bit          dec;
        bit          calc;
        logic [17:0] ins;
        logic [2:0]  st;
        bit          rw;
        bit          rc;
        bit          lcd;
        bit          err;
        logic [17:0] fld;
    } cyc_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    cyc_t        q[$];
    logic [17:0] m_instr;
    bit          m_err;

    module_control_unit_if bus();

    module_control_unit #(
        .READ_CYCLES (READ_CYCLES),
        .SHOW_CYCLES (SHOW_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void add(input logic [2:0] st, input bit rw, input bit rc, input bit lcd,
                                input bit snd, input bit dec, input bit calc);
        cyc_t c;
        c.rst  = 1'b0;
        c.pwr  = 1'b1;
        c.snd  = snd;
        c.dec  = dec;
        c.calc = calc;
        c.ins  = 18'($urandom);
        c.st   = st;
        c.rw   = rw;
        c.rc   = rc;
        c.lcd  = lcd;
        c.err  = m_err;
        c.fld  = m_instr;
        q.push_back(c);
    endfunction

    // kind: 0 none, 1 power drop, 2 reset; drop_at is relative to the send-press cycle
    function automatic void build_instr(input logic [17:0] instr, input int ddel, input int cdel,
                                        input bit hold, input int kind, input int drop_at);
        int          start;
        int          n;
        bit          tmo;
        logic [2:0]  op;
        tmo = 1'b0;
        op  = instr[17:15];
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) add(S_FETCH, 0, 0, 0, 0, rb(), rb());
        start = q.size();
        add(S_FETCH, 0, 0, 0, 1, rb(), rb());
        q[$].ins = instr;
        m_instr = instr;
        m_err   = 1'b0;

        n = (ddel < int'(TIMEOUT)) ? ddel + 1 : int'(TIMEOUT);
        for (int j = 0; j < n; j++) add(S_DECODE, 0, 0, 0, hold, (j == ddel), rb());
        if (ddel >= int'(TIMEOUT)) begin
            tmo = 1'b1;
        end else begin
            for (int j = 0; j < int'(READ_CYCLES); j++) add(S_READ, 0, 0, 0, hold, rb(), rb());
            n = (cdel < int'(TIMEOUT)) ? cdel + 1 : int'(TIMEOUT);
            for (int j = 0; j < n; j++) add(S_CALC, 0, 0, 0, hold, rb(), (j == cdel));
            if (cdel >= int'(TIMEOUT)) begin
                tmo = 1'b1;
            end else begin
                add(S_WAIT, 0, 0, 0, hold, rb(), rb());
                add(S_STORE, (op <= 3'd5), (op == 3'd6), 0, hold, rb(), rb());
                for (int j = 0; j < int'(SHOW_CYCLES); j++) add(S_SHOW, 0, 0, (j == 0), hold, rb(), rb());
            end
        end

        if (kind != 0 && start + drop_at < q.size()) begin
            while (q.size() > start + drop_at + 1) void'(q.pop_back());
            if (kind == 1) begin
                int n_off;
                q[$].pwr = 1'b0;
                n_off = int'($urandom_range(1, 3));
                for (int k = 0; k < n_off; k++) begin
                    add(S_OFF, 0, 0, 0, 0, rb(), rb());
                    q[$].pwr = (k == n_off - 1);
                end
            end else begin
                q[$].rst = 1'b1;
                m_instr  = '0;
                m_err    = 1'b0;
                add(S_OFF, 0, 0, 0, 0, rb(), rb());
            end
            add(S_FETCH, 0, 1, 0, 0, rb(), rb());
        end else begin
            if (tmo) m_err = 1'b1;
            if (hold) begin
                for (int k = 0; k < int'($urandom_range(3, 8)); k++) add(S_FETCH, 0, 0, 0, 1, rb(), rb());
            end
        end
    endfunction

    task automatic check_cycle(input string where, input cyc_t c);
        check_eq({"state", where}, 32'(bus.stateCPU), 32'(c.st));
        check_eq({"pulses", where}, 32'({bus.ramWrite, bus.ramClear, bus.lcdUpdate}),
                 32'({c.rw, c.rc, c.lcd}));
        check_eq({"error", where}, 32'(bus.error), 32'(c.err));
        check_eq({"fields", where},
                 32'({bus.opcode, bus.addrDest, bus.addrSrc1, bus.sinalImm, bus.Imm}), 32'(c.fld));
        check_eq({"src2", where}, 32'(bus.addrSrc2), 32'(c.fld[6:3]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc_t rc0;
        int   ddel, cdel, kind, r;
        reset = 1'b1;
        bus.power = 1'b1;
        bus.send = 1'b0;
        bus.instr = '0;
        bus.decoded = 1'b0;
        bus.calculated = 1'b0;
        m_instr = '0;
        m_err = 1'b0;

        add(S_OFF, 0, 0, 0, 0, 0, 0);
        q[$].pwr = 1'b0;
        add(S_OFF, 0, 0, 0, 0, 1, 1);
        q[$].pwr = 1'b0;
        add(S_OFF, 0, 0, 0, 0, 0, 0);
        add(S_FETCH, 0, 1, 0, 0, 0, 0);

        build_instr(18'b001_0011_0001_0010_000, 1, 1, 0, 0, 0);
        build_instr({3'b111, 15'($urandom)}, 0, 2, 0, 0, 0);
        build_instr({3'b110, 15'($urandom)}, 2, 0, 0, 0, 0);
        build_instr({3'b000, 15'($urandom)}, TIMEOUT, 0, 0, 0, 0);
        build_instr({3'b010, 15'($urandom)}, TIMEOUT - 1, TIMEOUT - 1, 0, 0, 0);
        build_instr({3'b011, 15'($urandom)}, 0, TIMEOUT, 0, 0, 0);
        build_instr({3'b101, 15'($urandom)}, 1, 3, 0, 1, 5);
        build_instr({3'b001, 15'($urandom)}, 1, 1, 1, 0, 0);
        build_instr({3'b000, 15'($urandom)}, 0, 0, 0, 2, 7);
        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 9));
            ddel = (r < 7) ? int'($urandom_range(0, 3)) :
                   (r < 9) ? int'($urandom_range(10, 14)) : int'(TIMEOUT + $urandom_range(0, 2));
            r = int'($urandom_range(0, 9));
            cdel = (r < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(13, 16));
            r = int'($urandom_range(0, 19));
            kind = (r < 2) ? 1 : (r == 2) ? 2 : 0;
            build_instr(18'($urandom), ddel, cdel, ($urandom_range(0, 4) == 0), kind,
                        int'($urandom_range(1, 30)));
        end
        add(S_FETCH, 0, 0, 0, 0, 0, 0);

        rc0.st = S_OFF; rc0.rw = 0; rc0.rc = 0; rc0.lcd = 0; rc0.err = 0; rc0.fld = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_cycle($sformatf("_rst%0d", i), rc0);
        end
        reset = 1'b0;

        for (int i = 0; i < q.size(); i++) begin
            check_cycle($sformatf("@%0d", i), q[i]);
            reset          = q[i].rst;
            bus.power      = q[i].pwr;
            bus.send       = q[i].snd;
            bus.instr      = q[i].ins;
            bus.decoded    = q[i].dec;
            bus.calculated = q[i].calc;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
